// File: rtl/rgb_pwm_pkg.sv
// Shared widths, colour field layout and the packed RGB type used by the
// RGB PWM driver and its per-channel comparators.
package rgb_pwm_pkg;

    localparam int CH_W    = 8;
    localparam int LIGHT_W = 24;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef logic [CH_W-1:0] duty_t;

    // Field order matches the light bus: R in [23:16], G in [15:8], B in [7:0].
    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_t;

    function automatic duty_t field_of(input logic [LIGHT_W-1:0] word, input int lsb);
        return word[lsb +: CH_W];
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One colour channel: holds the active duty value and drives a registered
// PWM output that is high while the shared period counter is below it.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  commit,
    input  duty_t commit_duty,
    input  duty_t cnt,
    output logic  led
);

    duty_t active;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would let led see the new active value
    // in the same edge and order-dependent simulation results would follow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
            led    <= 1'b0;
        end else begin
            if (commit) begin
                active <= commit_duty;
            end
            led <= (cnt < active);
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver: prescaled 8-bit period counter, a pending
// colour buffer with load/ack handshake, and period-aligned colour commits.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LIGHT_W-1:0] light,
    input  logic               load,
    output logic               ack,
    output logic               led_r,
    output logic               led_g,
    output logic               led_b,
    output logic               period_start
);

    localparam int PS_W = 16;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc;
    duty_t           cnt;
    logic            tick;
    logic            boundary;

    rgb_t            pending;
    logic            pending_valid;
    logic            commit;
    rgb_t            commit_rgb;

    assign tick     = (presc == PS_LAST);
    assign boundary = tick && (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + PS_W'(1);
            if (tick) begin
                cnt <= cnt + CH_W'(1);
            end
            period_start <= boundary;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            ack           <= 1'b0;
        end else begin
            ack <= load;
            if (load) begin
                pending <= rgb_t'(light);
            end
            if (boundary) begin
                pending_valid <= 1'b0;
            end else if (load) begin
                pending_valid <= 1'b1;
            end
        end
    end

    // NOTE: a load landing on the boundary edge bypasses the pending buffer,
    // so it must take priority over an older pending colour here.
    always_comb begin
        commit     = boundary && (load || pending_valid);
        commit_rgb = load ? rgb_t'(light) : pending;
    end

    pwm_channel u_red (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit),
        .commit_duty (field_of(LIGHT_W'(commit_rgb), R_LSB)),
        .cnt         (cnt),
        .led         (led_r)
    );

    pwm_channel u_green (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit),
        .commit_duty (field_of(LIGHT_W'(commit_rgb), G_LSB)),
        .cnt         (cnt),
        .led         (led_g)
    );

    pwm_channel u_blue (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit),
        .commit_duty (field_of(LIGHT_W'(commit_rgb), B_LSB)),
        .cnt         (cnt),
        .led         (led_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench for rgb_pwm_driver: whole-period duty measurements
// against a "last load before the boundary wins" colour model.
module tb_rgb_pwm_driver;

    localparam int P      = 4;
    localparam int PERIOD = 256 * P;

    logic        clk;
    logic        rst;
    logic [23:0] light;
    logic        load;
    logic        ack;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        period_start;

    int checks   = 0;
    int failures = 0;

    logic [23:0] shown;      // colour the model expects in the current period
    logic        prev_load;  // load value driven in the previous cycle
    logic [23:0] sched_val [0:PERIOD-1];
    bit          sched_en  [0:PERIOD-1];

    rgb_pwm_driver #(.PRESCALE(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .light        (light),
        .load         (load),
        .ack          (ack),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_sched();
        for (int i = 0; i < PERIOD; i++) begin
            sched_en[i]  = 1'b0;
            sched_val[i] = '0;
        end
    endtask

    // Waits (bounded) for a period_start sample; returns negedges waited.
    task automatic sync_period(input string name, output int waited);
        waited = 0;
        while (period_start !== 1'b1 && waited < 3 * PERIOD) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (period_start !== 1'b1) begin
            failures++;
            $display("FAIL %s_sync: period_start not seen after %0d cycles", name, waited);
        end
    endtask

    // Runs one full period starting on a period_start sample, applying the
    // load schedule and checking duty counts, period_start and ack.
    task automatic run_period(input string name);
        int hr, hg, hb, ps_err, ack_err, bad_k;
        logic [23:0] next;
        hr = 0; hg = 0; hb = 0; ps_err = 0; ack_err = 0; bad_k = -1;
        next = shown;
        for (int k = 0; k < PERIOD; k++) begin
            if (led_r === 1'b1) hr++;
            if (led_g === 1'b1) hg++;
            if (led_b === 1'b1) hb++;
            if (period_start !== (k == 0)) ps_err++;
            if (ack !== prev_load) begin
                ack_err++;
                if (bad_k < 0) bad_k = k;
            end
            if (sched_en[k]) begin
                load      = 1'b1;
                light     = sched_val[k];
                next      = sched_val[k];
                prev_load = 1'b1;
            end else begin
                load      = 1'b0;
                light     = 24'($urandom);
                prev_load = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (hr != int'(shown[23:16]) * P) begin
            failures++;
            $display("FAIL %s_red: high=%0d expected=%0d", name, hr, int'(shown[23:16]) * P);
        end
        checks++;
        if (hg != int'(shown[15:8]) * P) begin
            failures++;
            $display("FAIL %s_green: high=%0d expected=%0d", name, hg, int'(shown[15:8]) * P);
        end
        checks++;
        if (hb != int'(shown[7:0]) * P) begin
            failures++;
            $display("FAIL %s_blue: high=%0d expected=%0d", name, hb, int'(shown[7:0]) * P);
        end
        checks++;
        if (ps_err != 0) begin
            failures++;
            $display("FAIL %s_period_start: bad_cycles=%0d expected=0", name, ps_err);
        end
        checks++;
        if (ack_err != 0) begin
            failures++;
            $display("FAIL %s_ack: bad_cycles=%0d first_offset=%0d expected=0", name, ack_err, bad_k);
        end
        shown = next;
        clear_sched();
    endtask

    task automatic test_reset();
        int w;
        rst   = 1'b1;
        light = 24'hffffff;
        load  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, led_r, led_g, led_b, period_start} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got=%b expected=00000",
                     {ack, led_r, led_g, led_b, period_start});
        end
        rst       = 1'b0;
        load      = 1'b0;
        prev_load = 1'b0;
        shown     = '0;
        sync_period("reset", w);
        checks++;
        if (w != PERIOD) begin
            failures++;
            $display("FAIL reset_first_boundary: cycles=%0d expected=%0d", w, PERIOD);
        end
        run_period("reset_idle1");
        run_period("reset_idle2");
    endtask

    task automatic test_single_load();
        sched_en[100] = 1'b1; sched_val[100] = 24'hff0000;
        run_period("single_load");
        run_period("single_show");
    endtask

    task automatic test_two_channel();
        sched_en[500] = 1'b1; sched_val[500] = 24'h804000;
        run_period("two_ch_load");
        run_period("two_ch_show");
    endtask

    task automatic test_double_load();
        sched_en[200] = 1'b1; sched_val[200] = 24'h0000ff;
        sched_en[700] = 1'b1; sched_val[700] = 24'h00ff00;
        run_period("double_load");
        run_period("double_show");
    endtask

    task automatic test_boundary_load();
        sched_en[10] = 1'b1; sched_val[10] = 24'h000080;
        run_period("bnd_prep");
        sched_en[PERIOD-1] = 1'b1; sched_val[PERIOD-1] = 24'h00ff00;
        run_period("bnd_load");
        run_period("bnd_show");
    endtask

    task automatic test_back_to_back();
        for (int i = 300; i < 306; i++) begin
            sched_en[i]  = 1'b1;
            sched_val[i] = 24'($urandom);
        end
        run_period("b2b_load");
        run_period("b2b_show");
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) begin
                int off;
                off = ($urandom_range(0, 3) == 0) ? PERIOD - 1 : int'($urandom_range(0, PERIOD - 1));
                sched_en[off]  = 1'b1;
                sched_val[off] = 24'($urandom);
            end
            run_period($sformatf("rand%0d", p));
        end
        run_period("rand_last");
    endtask

    task automatic test_reset_mid();
        int w;
        sched_en[50] = 1'b1; sched_val[50] = 24'hffffff;
        run_period("mid_load");
        run_period("mid_full");
        repeat (300) @(negedge clk);
        checks++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            failures++;
            $display("FAIL mid_lit: got=%b expected=111", {led_r, led_g, led_b});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({led_r, led_g, led_b, ack, period_start} !== 5'b0) begin
            failures++;
            $display("FAIL mid_async_clear: got=%b expected=00000",
                     {led_r, led_g, led_b, ack, period_start});
        end
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        prev_load = 1'b0;
        shown     = '0;
        sync_period("mid_rst", w);
        checks++;
        if (w != PERIOD) begin
            failures++;
            $display("FAIL mid_first_boundary: cycles=%0d expected=%0d", w, PERIOD);
        end
        run_period("mid_dark");
        sched_en[600] = 1'b1; sched_val[600] = 24'h00ff00;
        run_period("mid_reload");
        run_period("mid_green");
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        light     = '0;
        prev_load = 1'b0;
        shown     = '0;
        clear_sched();
        @(negedge clk);
        test_reset();
        test_single_load();
        test_two_channel();
        test_double_load();
        test_boundary_load();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
